// File: rtl/ft_recovery_agent.sv
// Core-side agent for the fault-tolerance halt/shift/reset/resume protocol.
// Optional replay completeness check is enabled with `define FT_REPLAY_CHECK_EN.
module ft_recovery_agent #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int RESET_CYCLES  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  halt_i,
    input  logic                  shift_i,
    input  logic                  reset_i,
    input  logic                  resume_i,
    input  logic [ADDR_WIDTH-1:0] replay_addr_i,
    input  logic [DATA_WIDTH-1:0] replay_data_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    input  logic                  core_idle_i,
    output logic                  halted_o,
    output logic                  fetch_en_o,
    output logic                  core_reset_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  pc_set_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  drain_timeout_o,
    output logic                  replay_incomplete_o
);
    localparam int CNT_MAX = (DRAIN_TIMEOUT > RESET_CYCLES) ? DRAIN_TIMEOUT : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_HALTED,
        ST_RESET,
        ST_RESTORE
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  halted_q;
    logic                  fetch_en_q;
    logic                  core_reset_q;
    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic                  pc_set_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  drain_to_q;
    logic                  drain_done;

    assign drain_done = (state_q == ST_DRAIN) && (core_idle_i || (cnt_q == DRAIN_LAST));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            halted_q     <= 1'b0;
            fetch_en_q   <= 1'b1;
            core_reset_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            pc_set_q     <= 1'b0;
            pc_q         <= '0;
            drain_to_q   <= 1'b0;
        end else begin
            rf_we_q  <= 1'b0;
            pc_set_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (halt_i) begin
                        state_q    <= ST_DRAIN;
                        fetch_en_q <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                        if (!core_idle_i) drain_to_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // One event per cycle: reset beats shift beats resume; losers are dropped.
                ST_HALTED: begin
                    if (reset_i) begin
                        state_q      <= ST_RESET;
                        core_reset_q <= 1'b1;
                        cnt_q        <= '0;
                    end else if (shift_i) begin
                        rf_we_q    <= (replay_addr_i != '0);
                        rf_waddr_q <= replay_addr_i;
                        rf_wdata_q <= replay_data_i;
                    end else if (resume_i) begin
                        state_q  <= ST_RESTORE;
                        pc_set_q <= 1'b1;
                        pc_q     <= spc_i;
                    end
                end
                ST_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        state_q      <= ST_HALTED;
                        core_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESTORE: begin
                    state_q    <= ST_IDLE;
                    fetch_en_q <= 1'b1;
                    halted_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FT_REPLAY_CHECK_EN
    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0] wmap_q;
    logic             incomplete_q;
    logic             shift_take;
    logic             resume_take;

    assign shift_take  = (state_q == ST_HALTED) && !reset_i && shift_i;
    assign resume_take = (state_q == ST_HALTED) && !reset_i && !shift_i && resume_i;

    // Map is only cleared on a fresh halt, so a core reset mid-replay keeps progress.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wmap_q       <= '0;
            incomplete_q <= 1'b0;
        end else if (drain_done) begin
            wmap_q       <= '0;
            incomplete_q <= 1'b0;
        end else if (shift_take) begin
            wmap_q[replay_addr_i] <= 1'b1;
        end else if (resume_take) begin
            incomplete_q <= ~&wmap_q[NREGS-1:1];
        end
    end

    assign replay_incomplete_o = incomplete_q;
`else
    assign replay_incomplete_o = 1'b0;
`endif

    assign halted_o        = halted_q;
    assign fetch_en_o      = fetch_en_q;
    assign core_reset_o    = core_reset_q;
    assign rf_we_o         = rf_we_q;
    assign rf_waddr_o      = rf_waddr_q;
    assign rf_wdata_o      = rf_wdata_q;
    assign pc_set_o        = pc_set_q;
    assign pc_o            = pc_q;
    assign drain_timeout_o = drain_to_q;
endmodule

// File: tb/tb_ft_recovery_agent.sv
// Directed bench for ft_recovery_agent; expectations follow FT_REPLAY_CHECK_EN when defined.
module tb_ft_recovery_agent;
    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        halt_i, shift_i, reset_i, resume_i, core_idle_i;
    logic [4:0]  replay_addr_i;
    logic [31:0] replay_data_i, spc_i;
    logic        halted_o, fetch_en_o, core_reset_o, rf_we_o, pc_set_o;
    logic        drain_timeout_o, replay_incomplete_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, pc_o;

    int checks = 0;
    int errors = 0;

`ifdef FT_REPLAY_CHECK_EN
    localparam logic [31:0] EXP_INC = 32'd1;
`else
    localparam logic [31:0] EXP_INC = 32'd0;
`endif

    ft_recovery_agent dut (
        .clk_i(clk_i), .rst_n(rst_n), .halt_i(halt_i), .shift_i(shift_i),
        .reset_i(reset_i), .resume_i(resume_i), .replay_addr_i(replay_addr_i),
        .replay_data_i(replay_data_i), .spc_i(spc_i), .core_idle_i(core_idle_i),
        .halted_o(halted_o), .fetch_en_o(fetch_en_o), .core_reset_o(core_reset_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .pc_set_o(pc_set_o), .pc_o(pc_o), .drain_timeout_o(drain_timeout_o),
        .replay_incomplete_o(replay_incomplete_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic replay(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            shift_i       = 1'b1;
            replay_addr_i = 5'(a);
            replay_data_i = 32'(a * 3 + 32'h100);
            tick();
            chk("replay_we", {31'd0, rf_we_o}, 32'd1);
            chk("replay_addr", {27'd0, rf_waddr_o}, 32'(a));
            chk("replay_data", rf_wdata_o, 32'(a * 3 + 32'h100));
        end
        shift_i = 1'b0;
        tick();
        chk("replay_we_off", {31'd0, rf_we_o}, 32'd0);
    endtask

    task automatic do_resume(input logic [31:0] pc, input logic [31:0] exp_inc);
        resume_i = 1'b1;
        spc_i    = pc;
        tick();
        resume_i = 1'b0;
        spc_i    = 32'h0;
        chk("restore_pc_set", {31'd0, pc_set_o}, 32'd1);
        chk("restore_pc", pc_o, pc);
        chk("restore_halted", {31'd0, halted_o}, 32'd1);
        chk("restore_fetch", {31'd0, fetch_en_o}, 32'd0);
        chk("restore_incomplete", {31'd0, replay_incomplete_o}, exp_inc);
        tick();
        chk("idle_pc_set", {31'd0, pc_set_o}, 32'd0);
        chk("idle_fetch", {31'd0, fetch_en_o}, 32'd1);
        chk("idle_halted", {31'd0, halted_o}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        halt_i = 1'b0; shift_i = 1'b0; reset_i = 1'b0; resume_i = 1'b0;
        core_idle_i = 1'b0; replay_addr_i = '0; replay_data_i = '0; spc_i = '0;
        tick(); tick();
        chk("rst_fetch", {31'd0, fetch_en_o}, 32'd1);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        chk("rst_core_reset", {31'd0, core_reset_o}, 32'd0);
        chk("rst_we", {31'd0, rf_we_o}, 32'd0);
        chk("rst_pc_set", {31'd0, pc_set_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_timeout", {31'd0, drain_timeout_o}, 32'd0);
        chk("rst_incomplete", {31'd0, replay_incomplete_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Session 1: idle-driven drain.
        halt_i = 1'b1;
        shift_i = 1'b1; replay_addr_i = 5'd4;
        tick();
        shift_i = 1'b0;
        chk("s1_fetch_off", {31'd0, fetch_en_o}, 32'd0);
        chk("s1_drain_no_we", {31'd0, rf_we_o}, 32'd0);
        tick();
        chk("s1_not_halted", {31'd0, halted_o}, 32'd0);
        core_idle_i = 1'b1;
        tick();
        halt_i = 1'b0;
        core_idle_i = 1'b0;
        chk("s1_halted", {31'd0, halted_o}, 32'd1);
        chk("s1_timeout", {31'd0, drain_timeout_o}, 32'd0);

        shift_i = 1'b1; replay_addr_i = 5'd0; replay_data_i = 32'hDEAD;
        tick();
        chk("sh0_we", {31'd0, rf_we_o}, 32'd0);
        replay_addr_i = 5'd5; replay_data_i = 32'h1234;
        tick();
        chk("sh5_we", {31'd0, rf_we_o}, 32'd1);
        chk("sh5_addr", {27'd0, rf_waddr_o}, 32'd5);
        chk("sh5_data", rf_wdata_o, 32'h1234);
        replay_addr_i = 5'd31; replay_data_i = 32'hFFFFFFFF;
        tick();
        chk("sh31_we", {31'd0, rf_we_o}, 32'd1);
        chk("sh31_addr", {27'd0, rf_waddr_o}, 32'd31);
        chk("sh31_data", rf_wdata_o, 32'hFFFFFFFF);
        shift_i = 1'b0;
        tick();
        chk("sh_end_we", {31'd0, rf_we_o}, 32'd0);

        // Reset wins over a same-cycle shift; shifts during reset are ignored.
        reset_i = 1'b1; shift_i = 1'b1; replay_addr_i = 5'd7; replay_data_i = 32'h77;
        tick();
        reset_i = 1'b0; replay_addr_i = 5'd9;
        chk("rst_pulse_on", {31'd0, core_reset_o}, 32'd1);
        chk("rst_no_we", {31'd0, rf_we_o}, 32'd0);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_phase_no_we", {31'd0, rf_we_o}, 32'd0);
            if (core_reset_o) n++;
            else break;
        end
        shift_i = 1'b0;
        chk("rst_pulse_len", 32'(n), 32'd4);
        chk("rst_still_halted", {31'd0, halted_o}, 32'd1);
        shift_i = 1'b1; replay_addr_i = 5'd3; replay_data_i = 32'h33;
        tick();
        shift_i = 1'b0;
        chk("post_rst_we", {31'd0, rf_we_o}, 32'd1);
        chk("post_rst_addr", {27'd0, rf_waddr_o}, 32'd3);

        // Written so far: 3, 5, 31 -> incomplete when the check is built in.
        do_resume(32'h80, EXP_INC);

        // Session 2: drain forced by timeout.
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        chk("s2_fetch_off", {31'd0, fetch_en_o}, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (halted_o) break;
        end
        chk("s2_drain_cycles", 32'(n), 32'd16);
        chk("s2_timeout", {31'd0, drain_timeout_o}, 32'd1);
        chk("s2_inc_cleared", {31'd0, replay_incomplete_o}, 32'd0);
        replay(1, 30);
        do_resume(32'h100, EXP_INC);
        chk("s2_timeout_sticky", {31'd0, drain_timeout_o}, 32'd1);

        // Session 3: full replay.
        core_idle_i = 1'b1;
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        tick();
        core_idle_i = 1'b0;
        chk("s3_halted", {31'd0, halted_o}, 32'd1);
        replay(1, 31);
        do_resume(32'h0000_0444, 32'd0);
        chk("s3_timeout_sticky", {31'd0, drain_timeout_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ft_recovery_agent.md
Name: ft_recovery_agent

Overview:
- Core-side responder to the fault-tolerance controller's halt/shift/reset/resume protocol.
- Quiesces one core's fetch and acknowledges with halted_o.
- While halted, writes the replayed register stream (addr/data) into the core register file and pulses core reset on request.
- On resume, restores the PC from the saved SPC and re-enables fetch.

Parameters:
- ADDR_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, register and PC data width.
- DRAIN_TIMEOUT, 16, max cycles waiting for core_idle_i before forcing halted.
- RESET_CYCLES, 4, length of the core reset pulse in cycles.

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- halt_i  in  1  halt request from the controller (level).
- shift_i  in  1  replay beat valid (one register per cycle).
- reset_i  in  1  core reset request (single-cycle pulse).
- resume_i  in  1  resume request (single-cycle pulse).
- replay_addr_i  in  ADDR_WIDTH  replayed register address.
- replay_data_i  in  DATA_WIDTH  replayed register data.
- spc_i  in  DATA_WIDTH  saved PC to restore.
- core_idle_i  in  1  core pipeline empty.
- halted_o  out  1  halt acknowledge.
- fetch_en_o  out  1  core fetch enable.
- core_reset_o  out  1  active-high core reset pulse.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  ADDR_WIDTH  register-file write address.
- rf_wdata_o  out  DATA_WIDTH  register-file write data.
- pc_set_o  out  1  PC load strobe.
- pc_o  out  DATA_WIDTH  PC load value.
- drain_timeout_o  out  1  sticky flag: drain forced by timeout.
- replay_incomplete_o  out  1  see Optional Feature.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; fetch_en_o=1.
  - halted_o, core_reset_o, rf_we_o, pc_set_o, drain_timeout_o, replay_incomplete_o = 0.
  - rf_waddr_o, rf_wdata_o, pc_o = 0; all counters 0.
- All outputs are registered.
- State machine:
  - IDLE: halt_i=1 -> DRAIN; fetch_en_o falls to 0 on the next edge.
  - DRAIN: the counter increments each cycle.
    - core_idle_i=1 -> HALTED.
    - Counter reaches DRAIN_TIMEOUT-1 without idle -> HALTED, drain_timeout_o set (sticky until rst_n).
    - halted_o=1 from the first HALTED cycle.
  - HALTED: priority is reset_i > shift_i > resume_i. Lower-priority events in the same cycle are dropped; the controller must re-issue them.
    - reset_i -> RESET. core_reset_o=1 for exactly RESET_CYCLES cycles, then back to HALTED. shift_i and resume_i are ignored during RESET.
    - shift_i: latches replay_addr_i/replay_data_i. rf_we_o=1 with that addr/data on the following cycle (latency 1). Back-to-back shift_i gives a write every cycle.
    - Address 0 beats are consumed but produce rf_we_o=0 (x0 is hardwired).
    - resume_i -> RESTORE: pc_set_o=1, pc_o=spc_i (sampled on the resume_i cycle) for one cycle. Next cycle -> IDLE with fetch_en_o=1 and halted_o=0.
- halt_i is ignored outside IDLE.
- halt_i still high on return to IDLE re-enters DRAIN; the controller must drop halt_i before or with resume_i.
- shift_i, reset_i and resume_i are ignored in IDLE and DRAIN.
- An rf write pending from the last shift beat still completes if resume_i follows immediately. pc_set_o and that rf_we_o may coincide.

Optional Feature:
- Macro: FT_REPLAY_CHECK_EN.
- Enabled:
  - A (2^ADDR_WIDTH)-bit written-map is cleared on entry to HALTED.
  - Each shift beat sets its bit.
  - On resume_i, if any of registers 1..2^ADDR_WIDTH-1 is unwritten, replay_incomplete_o=1 (sticky until the next HALTED entry or rst_n). The resume still proceeds.
- Disabled: no map logic; replay_incomplete_o is tied to 0.

Test Plan:
- Reset release, then halt_i=1 with core_idle_i=1 two cycles later -> fetch_en_o=0 next edge; halted_o=1 in the cycle after idle; drain_timeout_o=0.
- halt_i with core_idle_i held 0 -> halted_o=1 after exactly 16 DRAIN cycles; drain_timeout_o=1 and stays 1.
- Halted, shift_i for 3 cycles with (0,0xDEAD),(5,0x1234),(31,0xFFFFFFFF) -> rf_we_o 0,1,1 one cycle later; waddr 5 then 31; data 0x1234 then 0xFFFFFFFF.
- Halted, reset_i and shift_i in the same cycle -> core_reset_o high exactly 4 cycles; no rf write; state returns to HALTED.
- Halted, resume_i with spc_i=0x00000080 -> pc_set_o=1 with pc_o=0x80 for one cycle; then fetch_en_o=1, halted_o=0.
- FT_REPLAY_CHECK_EN defined: resume after replaying only registers 1..30 -> replay_incomplete_o=1. Replaying 1..31 -> 0. Macro undefined: always 0.
